// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters and rr_grant_arbiter.
// master = requester side, slave = arbiter side.
`timescale 1ns/1ps
interface rr_grant_arbiter_if #(
    parameter int N = 8
);
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic         timeout;

    modport master (output req, output done, input gnt, input gnt_valid, input timeout);
    modport slave  (input req, input done, output gnt, output gnt_valid, output timeout);
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and a mandatory idle gap after release.
// Optional forced release after MAX_HOLD cycles is built when RR_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module rr_grant_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst,
    rr_grant_arbiter_if.slave   bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t         state_r;
    logic [N-1:0]   gnt_r;
    logic           gnt_valid_r;
    logic [IW-1:0]  ptr_r;
    logic [IW-1:0]  own_r;

    logic [N-1:0]   rot_s;
    logic [IW-1:0]  off_s;
    logic [IW:0]    sum_s;
    logic [IW-1:0]  pick_s;
    logic [IW-1:0]  next_ptr_s;
    logic           rel_s;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [CW-1:0]  hold_cnt_r;
    logic           timeout_r;
`endif

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, then map back to an index.
    always_comb begin
        rot_s = N'({bus.req, bus.req} >> ptr_r);
        off_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                off_s = IW'(i);
            end else begin
                off_s = off_s;
            end
        end
        sum_s = {1'b0, ptr_r} + {1'b0, off_s};
        if (sum_s >= (IW+1)'(N)) begin
            pick_s = IW'(sum_s - (IW+1)'(N));
        end else begin
            pick_s = sum_s[IW-1:0];
        end
        if (own_r == IW'(N - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = own_r + IW'(1);
        end
        rel_s = bus.done | ~bus.req[own_r];
    end

    // Grant state machine: IDLE searches, OWN holds until release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            gnt_r       <= '0;
            gnt_valid_r <= 1'b0;
            ptr_r       <= '0;
            own_r       <= '0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_r  <= '0;
            timeout_r   <= 1'b0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (|bus.req) begin
                        state_r     <= OWN;
                        gnt_r       <= N'(1) << pick_s;
                        gnt_valid_r <= 1'b1;
                        own_r       <= pick_s;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_cnt_r  <= '0;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                OWN: begin
                    // A normal release wins over a forced one on the same edge.
                    if (rel_s) begin
                        state_r     <= IDLE;
                        gnt_r       <= '0;
                        gnt_valid_r <= 1'b0;
                        ptr_r       <= next_ptr_s;
`ifdef RR_ARB_TIMEOUT_EN
                    end else if (hold_cnt_r == CW'(MAX_HOLD - 1)) begin
                        state_r     <= IDLE;
                        gnt_r       <= '0;
                        gnt_valid_r <= 1'b0;
                        ptr_r       <= next_ptr_s;
                        timeout_r   <= 1'b1;
                    end else begin
                        hold_cnt_r  <= hold_cnt_r + CW'(1);
                    end
`else
                    end else begin
                        state_r <= OWN;
                    end
`endif
                end
                default: begin
                    state_r     <= IDLE;
                    gnt_r       <= '0;
                    gnt_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_valid = gnt_valid_r;
`ifdef RR_ARB_TIMEOUT_EN
    assign bus.timeout   = timeout_r;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: directed scenarios plus random traffic
// checked against an owner/pointer reference model.
`timescale 1ns/1ps
module tb_rr_grant_arbiter;
    localparam int N        = 8;
    localparam int MAX_HOLD = 16;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_grant_arbiter_if #(.N(N)) bus ();

    rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // expected {timeout, gnt_valid, gnt} after each clock edge
    logic [N+1:0] exp_q[$];

    // reference model: owner index (-1 when idle), rotation pointer, cycles held
    int own_m  = -1;
    int ptr_m  = 0;
    int hold_m = 0;
    bit tmo_m  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input bit d, input bit rs);
        if (rs) begin
            own_m = -1; ptr_m = 0; hold_m = 0; tmo_m = 1'b0;
        end else if (own_m < 0) begin
            tmo_m = 1'b0;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (ptr_m + i) % N;
                if (own_m < 0 && r[k]) begin
                    own_m  = k;
                    hold_m = 0;
                end
            end
        end else begin
            bit rel_n;
            bit forced;
            rel_n  = d || !r[own_m];
            forced = TMO_EN && (hold_m == MAX_HOLD - 1);
            if (rel_n || forced) begin
                tmo_m = !rel_n;
                ptr_m = (own_m + 1) % N;
                own_m = -1;
            end else begin
                hold_m++;
                tmo_m = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] r, input bit d, input bit rs);
        logic [N-1:0] eg;
        @(negedge clk);
        bus.req  = r;
        bus.done = d;
        rst      = rs;
        model_step(r, d, rs);
        eg = (own_m >= 0) ? (N'(1) << own_m) : '0;
        exp_q.push_back({tmo_m, (own_m >= 0), eg});
    endtask

    // monitor: compare DUT outputs one step after each active edge
    initial begin
        logic [N+1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt", 32'(bus.gnt), 32'(e[N-1:0]));
                check("gnt_valid", 32'(bus.gnt_valid), 32'(e[N]));
                check("timeout", 32'(bus.timeout), 32'(e[N+1]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req  = '0;
        bus.done = 1'b0;

        // reset with all requests asserted, then first grant goes to bit 0
        repeat (3) step(8'hFF, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b0);

        // rotation: done pulsed in every owned cycle
        repeat (20) step(8'hFF, (own_m >= 0), 1'b0);

        // wrap: own bit 5, pointer 6, req 21 -> 01 then 20
        step(8'hFF, 1'b0, 1'b1);
        step(8'h20, 1'b0, 1'b0);
        step(8'h20, 1'b1, 1'b0);
        step(8'h21, 1'b0, 1'b0);
        step(8'h21, 1'b1, 1'b0);
        step(8'h21, 1'b0, 1'b0);
        step(8'h21, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);

        // drop and done together: single release, pointer 4
        step(8'h08, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h18, 1'b0, 1'b0);
        step(8'h18, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);

        // asynchronous reset between edges while bit 2 owns
        step(8'h04, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b1);
        #1;
        check("async_rst_gnt", 32'(bus.gnt), 32'h0);
        check("async_rst_valid", 32'(bus.gnt_valid), 32'h0);
        step(8'h04, 1'b0, 1'b0);
        step(8'h04, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);

        // long hold without done: forced release only in the timeout build
        repeat (24) step(8'h01, 1'b0, 1'b0);
        repeat (2) step(8'h00, 1'b0, 1'b0);

        // random traffic with sticky requests and occasional reset
        begin
            logic [N-1:0] r;
            r = '0;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 255));
                step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
            end
        end

        repeat (2) step(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("queue_drain", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
